// File: rtl/dec_onehot_seq_if.sv
// Request/response bundle for the one-hot index sequencer.
// The master side issues load/step/clear requests; the slave side returns the decode and status.
interface dec_onehot_seq_if #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 8
);
   logic               En;
   logic               Clear;
   logic               Load;
   logic               Step;
   logic               Dir;
   logic [WIDTH-1:0]   W;
   logic [0:DEPTH-1]   Y;
   logic [WIDTH-1:0]   Idx;
   logic               Active;
   logic               Wrap;
   logic               Err;

   modport master (
      output En, Clear, Load, Step, Dir, W,
      input  Y, Idx, Active, Wrap, Err
   );

   modport slave (
      input  En, Clear, Load, Step, Dir, W,
      output Y, Idx, Active, Wrap, Err
   );
endinterface

// File: rtl/dec_onehot_seq.sv
// Loadable up/down index register with a one-hot decode; serves as register-enable
// decoder or control-step ring sequencer. Index arithmetic is modulo DEPTH.
module dec_onehot_seq #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 8,
   parameter bit          WRAP  = 1'b1
) (
   input logic              Clock,
   input logic              Resetn,
   dec_onehot_seq_if.slave  bus
);

   localparam int unsigned      CMP_W    = WIDTH + 1;
   localparam logic [WIDTH-1:0] IDX_LAST = WIDTH'(DEPTH - 1);

   generate
      if ((DEPTH < 2) || (DEPTH > (2 ** WIDTH))) begin : g_bad_depth
         $error("dec_onehot_seq: DEPTH must lie in 2..2**WIDTH");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] idx_q;
   logic             wrap_q;
   logic             err_q;

   logic             load_ok_c;
   logic             at_top_c;
   logic             at_bot_c;
   logic             dec_en_c;
   logic [0:DEPTH-1] y_c;

   // Widen by one bit so DEPTH == 2**WIDTH compares without truncation.
   assign load_ok_c = ({1'b0, bus.W} < CMP_W'(DEPTH));
   assign at_top_c  = (idx_q == IDX_LAST);
   assign at_bot_c  = (idx_q == '0);

   // Priority: reset, clear, load, step; wrap/err are single-cycle pulses.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
         if (bus.Clear) begin
            state_q <= ST_IDLE;
         end else if (bus.Load) begin
            if (load_ok_c) begin
               idx_q   <= bus.W;
               state_q <= ST_ACTIVE;
            end else begin
               err_q <= 1'b1;
            end
         end else if (bus.Step && (state_q == ST_ACTIVE)) begin
            if (!bus.Dir) begin
               if (!at_top_c) begin
                  idx_q <= idx_q + WIDTH'(1);
               end else begin
                  wrap_q <= 1'b1;
                  if (WRAP) idx_q   <= '0;
                  else      state_q <= ST_IDLE;
               end
            end else begin
               if (!at_bot_c) begin
                  idx_q <= idx_q - WIDTH'(1);
               end else begin
                  wrap_q <= 1'b1;
                  if (WRAP) idx_q   <= IDX_LAST;
                  else      state_q <= ST_IDLE;
               end
            end
         end
      end
   end

   assign dec_en_c = bus.En && (state_q == ST_ACTIVE);

   // Combinational decode of registered state; idx_q never exceeds DEPTH-1.
   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_dec
         assign y_c[g] = dec_en_c && (idx_q == WIDTH'(g));
      end
   endgenerate

   assign bus.Y      = y_c;
   assign bus.Idx    = idx_q;
   assign bus.Active = (state_q == ST_ACTIVE);
   assign bus.Wrap   = wrap_q;
   assign bus.Err    = err_q;

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Directed bench for dec_onehot_seq across four parameter sets sharing one clock and reset.
module tb_dec_onehot_seq;

   logic Clock;
   logic Resetn;
   int   checks;
   int   failures;

   // b0: defaults, b1: DEPTH=6 wrap, b2: one-shot, b3: WIDTH=4 DEPTH=8
   dec_onehot_seq_if #(.WIDTH(3), .DEPTH(8)) b0 ();
   dec_onehot_seq_if #(.WIDTH(3), .DEPTH(6)) b1 ();
   dec_onehot_seq_if #(.WIDTH(3), .DEPTH(8)) b2 ();
   dec_onehot_seq_if #(.WIDTH(4), .DEPTH(8)) b3 ();

   dec_onehot_seq #(.WIDTH(3), .DEPTH(8), .WRAP(1'b1)) u0 (.Clock(Clock), .Resetn(Resetn), .bus(b0));
   dec_onehot_seq #(.WIDTH(3), .DEPTH(6), .WRAP(1'b1)) u1 (.Clock(Clock), .Resetn(Resetn), .bus(b1));
   dec_onehot_seq #(.WIDTH(3), .DEPTH(8), .WRAP(1'b0)) u2 (.Clock(Clock), .Resetn(Resetn), .bus(b2));
   dec_onehot_seq #(.WIDTH(4), .DEPTH(8), .WRAP(1'b1)) u3 (.Clock(Clock), .Resetn(Resetn), .bus(b3));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_all();
      b0.Clear = 0; b0.Load = 0; b0.Step = 0; b0.Dir = 0; b0.W = '0;
      b1.Clear = 0; b1.Load = 0; b1.Step = 0; b1.Dir = 0; b1.W = '0;
      b2.Clear = 0; b2.Load = 0; b2.Step = 0; b2.Dir = 0; b2.W = '0;
      b3.Clear = 0; b3.Load = 0; b3.Step = 0; b3.Dir = 0; b3.W = '0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      Resetn   = 1'b0;
      b0.En = 1; b1.En = 1; b2.En = 1; b3.En = 1;
      idle_all();

      // Reset for two edges
      tick(); tick();
      chk("rst_y0",      64'(b0.Y),      64'h00);
      chk("rst_active0", 64'(b0.Active), 64'h0);
      chk("rst_idx0",    64'(b0.Idx),    64'h0);
      chk("rst_wrap0",   64'(b0.Wrap),   64'h0);
      chk("rst_err0",    64'(b0.Err),    64'h0);
      chk("rst_y3",      64'(b3.Y),      64'h00);

      // Load 3
      Resetn = 1'b1;
      b0.Load = 1; b0.W = 3'd3;
      tick();
      chk("ld3_idx",    64'(b0.Idx),    64'h3);
      chk("ld3_y",      64'(b0.Y),      64'(8'b00010000));
      chk("ld3_active", 64'(b0.Active), 64'h1);

      // Load 6 then step up three times through the wrap
      b0.W = 3'd6;
      tick();
      chk("ld6_idx", 64'(b0.Idx), 64'h6);
      b0.Load = 0; b0.Step = 1; b0.Dir = 0;
      tick();
      chk("up1_idx",  64'(b0.Idx),  64'h7);
      chk("up1_wrap", 64'(b0.Wrap), 64'h0);
      chk("up1_y",    64'(b0.Y),    64'(8'b00000001));
      tick();
      chk("up2_idx",  64'(b0.Idx),  64'h0);
      chk("up2_wrap", 64'(b0.Wrap), 64'h1);
      chk("up2_y",    64'(b0.Y),    64'(8'b10000000));
      tick();
      chk("up3_idx",  64'(b0.Idx),  64'h1);
      chk("up3_wrap", 64'(b0.Wrap), 64'h0);
      chk("up3_y",    64'(b0.Y),    64'(8'b01000000));

      // Load with step: load wins
      b0.Load = 1; b0.W = 3'd2;
      tick();
      chk("ldstep_idx", 64'(b0.Idx), 64'h2);

      // En toggling
      b0.Step = 0; b0.W = 3'd4;
      tick();
      chk("en_ld4_y", 64'(b0.Y), 64'(8'b00001000));
      b0.Load = 0; b0.En = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("en_off_y",      64'(b0.Y),      64'h00);
         chk("en_off_idx",    64'(b0.Idx),    64'h4);
         chk("en_off_active", 64'(b0.Active), 64'h1);
      end
      b0.En = 1;
      tick();
      chk("en_on_y", 64'(b0.Y), 64'(8'b00001000));

      // Clear holds the index; steps while inactive do nothing
      b0.Clear = 1;
      tick();
      chk("clr_active", 64'(b0.Active), 64'h0);
      chk("clr_idx",    64'(b0.Idx),    64'h4);
      chk("clr_y",      64'(b0.Y),      64'h00);
      b0.Clear = 0; b0.Step = 1; b0.Dir = 0;
      tick();
      chk("inact_step_idx",  64'(b0.Idx),  64'h4);
      chk("inact_step_wrap", 64'(b0.Wrap), 64'h0);
      b0.Step = 0;

      // DEPTH=6: step down through the wrap, then out-of-range load
      b1.Load = 1; b1.W = 3'd1;
      tick();
      b1.Load = 0; b1.Step = 1; b1.Dir = 1;
      tick();
      chk("d6_dn1_idx",  64'(b1.Idx),  64'h0);
      chk("d6_dn1_wrap", 64'(b1.Wrap), 64'h0);
      tick();
      chk("d6_dn2_idx",  64'(b1.Idx),  64'h5);
      chk("d6_dn2_wrap", 64'(b1.Wrap), 64'h1);
      chk("d6_dn2_y",    64'(b1.Y),    64'(6'b000001));
      b1.Step = 0; b1.Load = 1; b1.W = 3'd6;
      tick();
      chk("d6_ld6_err",    64'(b1.Err),    64'h1);
      chk("d6_ld6_idx",    64'(b1.Idx),    64'h5);
      chk("d6_ld6_active", 64'(b1.Active), 64'h1);
      chk("d6_ld6_y",      64'(b1.Y),      64'(6'b000001));
      b1.Load = 0;
      tick();
      chk("d6_err_clr", 64'(b1.Err), 64'h0);
      b1.Step = 1; b1.Dir = 0;
      tick();
      chk("d6_up_wrap_idx",  64'(b1.Idx),  64'h0);
      chk("d6_up_wrap_wrap", 64'(b1.Wrap), 64'h1);
      b1.Step = 0;

      // One-shot: stop at the top
      b2.Load = 1; b2.W = 3'd6;
      tick();
      b2.Load = 0; b2.Step = 1; b2.Dir = 0;
      tick();
      chk("os_up1_idx",    64'(b2.Idx),    64'h7);
      chk("os_up1_active", 64'(b2.Active), 64'h1);
      chk("os_up1_wrap",   64'(b2.Wrap),   64'h0);
      tick();
      chk("os_up2_idx",    64'(b2.Idx),    64'h7);
      chk("os_up2_active", 64'(b2.Active), 64'h0);
      chk("os_up2_wrap",   64'(b2.Wrap),   64'h1);
      chk("os_up2_y",      64'(b2.Y),      64'h00);
      tick();
      chk("os_up3_idx",  64'(b2.Idx),  64'h7);
      chk("os_up3_wrap", 64'(b2.Wrap), 64'h0);
      // One-shot at the bottom
      b2.Step = 0; b2.Load = 1; b2.W = 3'd0;
      tick();
      b2.Load = 0; b2.Step = 1; b2.Dir = 1;
      tick();
      chk("os_dn_idx",    64'(b2.Idx),    64'h0);
      chk("os_dn_active", 64'(b2.Active), 64'h0);
      chk("os_dn_wrap",   64'(b2.Wrap),   64'h1);
      b2.Step = 0;

      // WIDTH=4, DEPTH=8: range checks and modulo-DEPTH wrap
      b3.Load = 1; b3.W = 4'd2;
      tick();
      chk("w4_ld2_active", 64'(b3.Active), 64'h1);
      b3.Clear = 1; b3.W = 4'd9;
      tick();
      chk("w4_clrld_active", 64'(b3.Active), 64'h0);
      chk("w4_clrld_err",    64'(b3.Err),    64'h0);
      b3.Clear = 0; b3.W = 4'd9;
      tick();
      chk("w4_ld9_err",    64'(b3.Err),    64'h1);
      chk("w4_ld9_active", 64'(b3.Active), 64'h0);
      chk("w4_ld9_idx",    64'(b3.Idx),    64'h2);
      b3.W = 4'd8;
      tick();
      chk("w4_ld8_err", 64'(b3.Err), 64'h1);
      b3.W = 4'd7;
      tick();
      chk("w4_ld7_err", 64'(b3.Err), 64'h0);
      chk("w4_ld7_y",   64'(b3.Y),   64'(8'b00000001));
      b3.Load = 0; b3.Step = 1; b3.Dir = 0;
      tick();
      chk("w4_wrap_idx",  64'(b3.Idx),  64'h0);
      chk("w4_wrap_wrap", 64'(b3.Wrap), 64'h1);
      b3.Step = 0;

      // Reset overrides a load
      Resetn = 1'b0; b0.Load = 1; b0.W = 3'd5;
      tick();
      chk("rstld_idx",    64'(b0.Idx),    64'h0);
      chk("rstld_active", 64'(b0.Active), 64'h0);
      chk("rstld_y",      64'(b0.Y),      64'h00);
      Resetn = 1'b1;
      idle_all();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
